// File: rtl/uart_pkg.sv
// Shared UART definitions for the Rx and Tx paths: FSM state encoding and parity type constants.
// Latency: n/a (package). Backpressure: n/a.
// Ports: none. Provides uart_state_t, PAR_EVEN/PAR_ODD and a parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // red_xor is the XOR-reduction of the data word; odd parity inverts it.
  function automatic logic parity_bit(input logic red_xor, input logic par_typ);
    return red_xor ^ (par_typ == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter for the UART transmitter; pulses bit_done on the last cycle of each bit.
// Latency: bit_done is combinational from the counter; one bit lasts max(prescale,1) cycles.
// Backpressure: none; the counter free-runs while run is high and restarts on clear.
// Ports: CLK, RST (async active-low), clear (restart count), run (frame active),
//        prescale (cycles per bit, 0 treated as 1), bit_done (last cycle of current bit).
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      clear,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      bit_done
);

  logic [PRESCALE_WIDTH-1:0] cnt;
  logic [PRESCALE_WIDTH-1:0] last;

  // A prescale of zero gives a one-cycle bit, same as a prescale of one.
  assign last     = (prescale == '0) ? '0 : prescale - 1'b1;
  assign bit_done = run && (cnt == last);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt <= '0;
    end else if (clear || bit_done) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, WIDTH data bits LSB first, optional parity, stop bit(s).
// Latency: TX_OUT/Busy change on the accept edge; frame = (2+WIDTH+PAR_EN)*Prescale cycles.
// Backpressure: Data_Valid is only taken in IDLE; requests while Busy are dropped, not queued.
// Ports: CLK, RST (async active-low), P_DATA, Data_Valid, PAR_EN, PAR_TYP (0 even, 1 odd),
//        Prescale (cycles per bit), TX_OUT (registered serial line, idle high), Busy (registered).
// Build option: define UART_TX_TWO_STOP_EN for a two-bit-time stop period.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [WIDTH-1:0]          P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  uart_state_t               state;
  logic [WIDTH-1:0]          data_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic [PRESCALE_WIDTH-1:0] prescale_q;
  logic [IDX_W-1:0]          bit_idx;
  logic [IDX_W-1:0]          nxt_idx;
  logic                      accept;
  logic                      bit_done;
  logic                      par_bit;
`ifdef UART_TX_TWO_STOP_EN
  logic                      stop_cnt;
`endif

  assign accept  = (state == IDLE) && Data_Valid;
  assign nxt_idx = bit_idx + 1'b1;
  assign par_bit = parity_bit(^data_q, par_typ_q);

  // Timer runs from the latched prescale so mid-frame Prescale changes are invisible.
  uart_tx_bit_timer #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_bit_timer (
    .CLK      (CLK),
    .RST      (RST),
    .clear    (accept),
    .run      (state != IDLE),
    .prescale (prescale_q),
    .bit_done (bit_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      TX_OUT     <= 1'b1;
      Busy       <= 1'b0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
      bit_idx    <= '0;
`ifdef UART_TX_TWO_STOP_EN
      stop_cnt   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Data_Valid) begin
            data_q     <= P_DATA;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            prescale_q <= Prescale;
            bit_idx    <= '0;
            state      <= START;
            TX_OUT     <= 1'b0;
            Busy       <= 1'b1;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt   <= 1'b0;
`endif
          end else begin
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
          end
        end
        START: begin
          if (bit_done) begin
            state  <= DATA;
            TX_OUT <= data_q[0];
          end
        end
        DATA: begin
          if (bit_done) begin
            if (bit_idx == LAST_IDX) begin
              if (par_en_q) begin
                state  <= PARITY;
                TX_OUT <= par_bit;
              end else begin
                state  <= STOP;
                TX_OUT <= 1'b1;
              end
            end else begin
              bit_idx <= nxt_idx;
              TX_OUT  <= data_q[nxt_idx];
            end
          end
        end
        PARITY: begin
          if (bit_done) begin
            state  <= STOP;
            TX_OUT <= 1'b1;
          end
        end
        STOP: begin
          if (bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
            // First stop bit-time done: stay for a second one.
            if (!stop_cnt) begin
              stop_cnt <= 1'b1;
            end else begin
              state  <= IDLE;
              Busy   <= 1'b0;
              TX_OUT <= 1'b1;
            end
`else
            state  <= IDLE;
            Busy   <= 1'b0;
            TX_OUT <= 1'b1;
`endif
          end
        end
        default: begin
          state  <= IDLE;
          Busy   <= 1'b0;
          TX_OUT <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: directed frames with hand-built bit sequences,
// mid-frame disturbance, mid-frame reset, Prescale=0, and a 256-byte loopback decode.
// Ports: none (top-level bench).
module tb_uart_tx_framer;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [4:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic smp [0:1023];

  uart_tx_framer #(.WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge. expv[i] is the i-th bit on the line (start bit at 0), one stop bit
  // included in nb. Samples every negedge while Busy is high, bounded to 600 cycles.
  task automatic send_frame(input string tag, input logic [7:0] d, input logic pe,
                            input logic pt, input logic [4:0] ps, input logic [15:0] expv,
                            input int nb, input int dist_at, input int rst_at);
    logic [15:0] ev;
    int n, eff, len, bad;
    logic eb;
    ev = expv;
    n  = nb;
    if (STOPS == 2) begin
      ev[n] = 1'b1;
      n++;
    end
    eff = (ps == 5'd0) ? 1 : int'(ps);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; Prescale = ps; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    len = 0;
    bad = 0;
    while (Busy === 1'b1 && len < 600) begin
      smp[len] = TX_OUT;
      eb = (len / eff < n) ? ev[len / eff] : 1'b1;
      if (TX_OUT !== eb) bad++;
      if (len == rst_at) begin
        RST = 1'b0;
        #1;
        chk({tag, "_rst_tx"}, 32'(TX_OUT), 32'd1);
        chk({tag, "_rst_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_pre_rst_wave"}, bad, 0);
        @(negedge CLK);
        RST = 1'b1;
        return;
      end
      if (len == dist_at) begin
        Data_Valid = 1'b1; P_DATA = 8'h3C; Prescale = 5'd4; PAR_EN = ~pe;
      end else if (len == dist_at + 1) begin
        Data_Valid = 1'b0;
      end
      len++;
      @(negedge CLK);
    end
    chk({tag, "_busy_len"}, len, n * eff);
    chk({tag, "_wave"}, bad, 0);
    chk({tag, "_idle_tx"}, 32'(TX_OUT), 32'd1);
  endtask

  initial begin
    int bc;
    logic [7:0] rd, rx_d;
    logic rpt, rpar, rx_p;
    int rps;

    RST = 1'b1; P_DATA = '0; Data_Valid = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = '0;
    #2 RST = 1'b0;
    #1;
    chk("reset_tx", 32'(TX_OUT), 32'd1);
    chk("reset_busy", 32'(Busy), 32'd0);
    repeat (3) @(negedge CLK);
    chk("reset_hold_tx", 32'(TX_OUT), 32'd1);
    RST = 1'b1;

    // 0xA5 even parity: 0, 1,0,1,0,0,1,0,1, par 0, stop 1 -> 88 cycles.
    send_frame("a5_even", 8'hA5, 1'b1, 1'b0, 5'd8, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1, -1);
    // 0x01 odd parity: parity bit 0 -> 176 cycles. Sent back-to-back in first idle cycle.
    send_frame("01_odd", 8'h01, 1'b1, 1'b1, 5'd16, {5'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, -1, -1);
    chk("01_odd_par_bit", 32'(smp[9*16+8]), 32'd0);
    // 0xFF no parity: 0, eight 1s, stop -> 80 cycles.
    send_frame("ff_nopar", 8'hFF, 1'b0, 1'b0, 5'd8, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, -1, -1);

    // Disturbance at cycle 20: 0x3C with Prescale 4 must neither alter nor follow the frame.
    send_frame("a5_dist", 8'hA5, 1'b1, 1'b0, 5'd8, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, 20, -1);
    bc = 0;
    repeat (20) begin
      @(negedge CLK);
      if (Busy !== 1'b0) bc++;
    end
    chk("dist_no_queue", bc, 0);

    // Reset at cycle 30, then a fresh complete frame on the first edge after release.
    send_frame("a5_rst", 8'hA5, 1'b1, 1'b0, 5'd8, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1, 30);
    send_frame("a5_fresh", 8'hA5, 1'b1, 1'b0, 5'd8, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1, -1);

    // Prescale 0 behaves as 1 cycle per bit.
    send_frame("ps0", 8'h55, 1'b0, 1'b0, 5'd0, {6'b0, 1'b1, 8'h55, 1'b0}, 10, -1, -1);

    // Loopback: mid-bit receiver decode of 256 random bytes, both parity types.
    for (int i = 0; i < 256; i++) begin
      rd   = 8'($urandom);
      rpt  = 1'($urandom);
      rps  = (i % 2 == 0) ? 8 : 16;
      rpar = (^rd) ^ rpt;
      send_frame($sformatf("lb%0d", i), rd, 1'b1, rpt, 5'(rps),
                 {5'b0, 1'b1, rpar, rd, 1'b0}, 11, -1, -1);
      for (int k = 0; k < 8; k++) rx_d[k] = smp[(k + 1) * rps + rps / 2];
      rx_p = smp[9 * rps + rps / 2];
      chk($sformatf("lb%0d_rx_data", i), 32'(rx_d), 32'(rd));
      chk($sformatf("lb%0d_par_err", i), 32'(rx_p != ((^rx_d) ^ rpt)), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame.
REQ-002 Parameter PRESCALE_WIDTH, default 5, width of Prescale and internal bit counter.
REQ-003 CLK  input  1  clock; all state changes on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-low.
REQ-005 P_DATA  input  WIDTH  parallel data to transmit.
REQ-006 Data_Valid  input  1  request to send P_DATA.
REQ-007 PAR_EN  input  1  1 = parity bit appended after data.
REQ-008 PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-009 Prescale  input  PRESCALE_WIDTH  CLK cycles per transmitted bit.
REQ-010 TX_OUT  output  1  serial line, registered, idle high.
REQ-011 Busy  output  1  registered, high while a frame is in progress.

Function
REQ-012 The block SHALL implement the states IDLE, START, DATA, PARITY, STOP.
REQ-013 In IDLE with Data_Valid=1, the block SHALL, on that edge, latch P_DATA, PAR_EN, PAR_TYP and Prescale, enter START, drive TX_OUT=0 and Busy=1.
REQ-014 Data_Valid while not in IDLE SHALL be ignored; no queueing.
REQ-015 Each bit SHALL be held on TX_OUT for exactly the latched Prescale cycles; a latched value of 0 SHALL be treated as 1.
REQ-016 Inputs changing mid-frame SHALL NOT affect the frame in progress.
REQ-017 DATA SHALL send the WIDTH latched bits LSB first.
REQ-018 Parity bit SHALL be XOR of latched data when PAR_TYP=0, XNOR when PAR_TYP=1.
REQ-019 After DATA, the FSM SHALL enter PARITY if latched PAR_EN=1, else STOP.
REQ-020 STOP SHALL drive TX_OUT=1 for one bit time, then enter IDLE with Busy=0.
REQ-021 TX_OUT SHALL be 1 in IDLE.
REQ-022 Frame length (accept edge to Busy falling edge) SHALL be (2+WIDTH+PAR_EN)*Prescale cycles.
REQ-023 A new frame SHALL be acceptable in the first IDLE cycle; minimum inter-frame gap is one CLK cycle of idle-high.

Reset
REQ-024 RST low SHALL immediately force state IDLE, TX_OUT=1, Busy=0, counters and latched registers to 0, including mid-frame.
REQ-025 The first edge after RST release SHALL be able to accept Data_Valid.

Configuration
REQ-026 With UART_TX_TWO_STOP_EN defined, STOP SHALL last 2*Prescale cycles and REQ-022 length becomes (3+WIDTH+PAR_EN)*Prescale.
REQ-027 Without UART_TX_TWO_STOP_EN, STOP SHALL last one bit time.

Structure
REQ-028 State encoding and parity constants (PAR_EVEN=0, PAR_ODD=1) SHALL live in the shared package uart_pkg, common to Rx and Tx.
REQ-029 The per-bit cycle counter with bit_done pulse SHALL be sub-module uart_tx_bit_timer; bit index counter and FSM stay in the top.

Verification
REQ-030 P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, Prescale=8 -> TX_OUT bits 0,1,0,1,0,0,1,0,1,0,1 each 8 cycles; Busy high 88 cycles.
REQ-031 P_DATA=0x01, PAR_EN=1, PAR_TYP=1, Prescale=16 -> parity bit 0; Busy high 176 cycles.
REQ-032 P_DATA=0xFF, PAR_EN=0, Prescale=8 -> 0, eight 1s, stop 1; Busy high 80 cycles.
REQ-033 Data_Valid pulsed with P_DATA=0x3C during a 0xA5 frame, Prescale changed to 4 mid-frame -> 0xA5 frame unchanged at 8 cycles/bit, 0x3C never sent.
REQ-034 RST low at cycle 30 of a 0xA5 frame -> TX_OUT=1, Busy=0 immediately; next Data_Valid after release sends a complete fresh frame.
REQ-035 Loopback into the Rx path, 256 random bytes, both parity types, Prescale 8/16 -> all bytes received, Par_Err never set; UART_TX_TWO_STOP_EN build repeated.
